instr_fetch: RTL

Instruction fetch/issue unit that is the upstream driver of the IR+ALU execute stage. It holds a small program memory loaded through a write port. On `start` it walks the program from address 0 and presents each 32-bit instruction word on `ir` with a valid/ready handshake. The execute stage consumes one word per handshake, and the fetch unit signals completion after the last word is accepted.

---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction issue channel between the fetch unit and the execute stage.
// Latency: none; this is a bundle of wires.
// Backpressure: the execute stage holds off the fetch unit by keeping ir_ready low.
//
// Signals:
//   ir       - 32-bit instruction word from the fetch unit
//   ir_valid - ir holds a valid instruction
//   ir_ready - execute stage accepts ir this cycle
//   ill_op   - presented opcode is outside the supported set (qualify with ir_valid)
interface instr_fetch_if;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        ill_op;

  // Fetch unit drives the word and its qualifiers, and samples ready.
  modport master (
    output ir,
    output ir_valid,
    output ill_op,
    input  ir_ready
  );

  // Execute stage consumes the word and drives ready.
  modport slave (
    input  ir,
    input  ir_valid,
    input  ill_op,
    output ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: walks a loadable program memory and issues words to execute.
// Latency: start at edge N -> first ir_valid after edge N+1; one word per 2 cycles at best.
// Backpressure: ISSUE holds ir/ill_op/pc stable while ir_ready is low; nothing is dropped.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   load_en/addr/data   - program memory write port, accepted only while idle
//   prog_len            - number of words to issue, sampled on an accepted start
//   start               - begin a run from address 0, accepted only while idle
//   iss                 - issue channel (ir, ir_valid, ir_ready, ill_op)
//   pc                  - address of the word being fetched or presented
//   busy                - high whenever not idle
//   done                - one-cycle pulse after the last word is accepted
module instr_fetch #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  instr_fetch_if.master     iss,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  // Highest opcode the execute stage understands (movsgpr, mov, add, sub, mul).
  localparam logic [4:0] MAX_OPCODE = 5'd4;

  // DEPTH expressed in the width of prog_len so the clamp compares like widths.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t state_q;
  state_t state_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_rd;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [31:0]       ir_q;
  logic              ill_q;
  logic              last_word;

  // Datapath enables decoded by the FSM.
  logic start_acc;
  logic fetch_en;
  logic pc_inc;

  // --------------------------------------------------------------------------
  // Program memory: no reset, so a reset mid-run leaves the program intact.
  // A write in the same idle cycle as start lands before the first FETCH reads it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  assign mem_rd = mem[pc_q];

  // Runs longer than the memory stop at the last address instead of wrapping.
  assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

  // len_q is never zero in ISSUE (zero-length runs skip straight to DONE),
  // so len_q - 1 cannot underflow where this is used.
  assign last_word = ({1'b0, pc_q} == (len_q - 1'b1));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath enables
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    fetch_en  = 1'b0;
    pc_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (len_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        // ir_valid is implied by being in ISSUE, so ready alone completes a transfer.
        if (iss.ir_ready) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: run length, program counter, presented word and flag.
  // ir and ill_op only change in FETCH, which keeps them stable across a stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q <= len_clamped;
        pc_q  <= '0;
      end else if (pc_inc) begin
        pc_q  <= pc_q + 1'b1;
      end
      if (fetch_en) begin
        ir_q  <= mem_rd;
        ill_q <= (mem_rd[31:27] > MAX_OPCODE);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all from registers or decoded state, none from ir_ready.
  // --------------------------------------------------------------------------
  assign iss.ir       = ir_q;
  assign iss.ill_op   = ill_q;
  assign iss.ir_valid = (state_q == S_ISSUE);
  assign pc           = pc_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule
